// File: rtl/minesweeper_reveal_engine.sv
// Flood-fill reveal engine: uncovers a start cell and walks its zero region via a FIFO.
// Optional MS_REVEAL_STATS_EN adds the revealed_count output.
module minesweeper_reveal_engine #(
    parameter int ROWS   = 16,
    parameter int COLS   = 16,
    parameter int QDEPTH = ROWS * COLS,
    localparam int RW = $clog2(ROWS),
    localparam int CW = $clog2(COLS),
    localparam int AW = $clog2(ROWS * COLS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [RW-1:0] start_row,
    input  logic [CW-1:0] start_col,
    output logic          busy,
    output logic          done,
    output logic          bomb_hit,
    output logic          overflow,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd_en,
    input  logic [5:0]    mem_rdata,
    output logic          mem_wr_en,
    output logic [5:0]    mem_wdata
`ifdef MS_REVEAL_STATS_EN
    ,
    output logic [AW:0]   revealed_count
`endif
);

    localparam int PW   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNTW = $clog2(QDEPTH + 1);
    localparam int EW   = RW + CW;

    typedef enum logic [2:0] {IDLE, POP, CHECK, EXPAND, DONE} state_t;

    state_t                 state, state_n;
    logic [EW-1:0]          fifo_mem [QDEPTH];
    logic [PW-1:0]          rd_ptr, wr_ptr;
    logic [CNTW-1:0]        cnt;
    logic [ROWS*COLS-1:0]   queued;
    logic [RW-1:0]          cur_row, nb_row, head_row;
    logic [CW-1:0]          cur_col, nb_col, head_col;
    logic [2:0]             k;
    logic                   accept, pop_en, nb_ok, nb_push, nb_drop;
    logic                   q_full;
    logic [AW-1:0]          nb_addr, start_addr;

    function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] r,
                                                 input logic [CW-1:0] c);
        return AW'(r) * AW'(COLS) + AW'(c);
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign accept     = (state == IDLE) && start;
    assign head_row   = fifo_mem[rd_ptr][EW-1:CW];
    assign head_col   = fifo_mem[rd_ptr][CW-1:0];
    assign start_addr = cell_addr(start_row, start_col);
    assign nb_addr    = cell_addr(nb_row, nb_col);
    assign q_full     = (cnt == CNTW'(QDEPTH));
    assign nb_push    = (state == EXPAND) && nb_ok && !queued[nb_addr] && !q_full;
    assign nb_drop    = (state == EXPAND) && nb_ok && !queued[nb_addr] && q_full;

    // Neighbour k in NW,N,NE,W,E,SW,S,SE order, with edge clipping.
    always_comb begin
        nb_row = cur_row;
        nb_col = cur_col;
        nb_ok  = 1'b1;
        if (k <= 3'd2) begin
            nb_ok  = nb_ok && (cur_row != '0);
            nb_row = cur_row - RW'(1);
        end
        if (k >= 3'd5) begin
            nb_ok  = nb_ok && (cur_row != RW'(ROWS - 1));
            nb_row = cur_row + RW'(1);
        end
        if (k == 3'd0 || k == 3'd3 || k == 3'd5) begin
            nb_ok  = nb_ok && (cur_col != '0);
            nb_col = cur_col - CW'(1);
        end
        if (k == 3'd2 || k == 3'd4 || k == 3'd7) begin
            nb_ok  = nb_ok && (cur_col != CW'(COLS - 1));
            nb_col = cur_col + CW'(1);
        end
    end

    // Next-state and RAM port control.
    always_comb begin
        state_n   = state;
        pop_en    = 1'b0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state)
            IDLE: if (start) state_n = POP;
            POP: begin
                if (cnt == '0) begin
                    state_n = DONE;
                end else begin
                    pop_en    = 1'b1;
                    mem_rd_en = 1'b1;
                    mem_addr  = cell_addr(head_row, head_col);
                    state_n   = CHECK;
                end
            end
            CHECK: begin
                mem_addr = cell_addr(cur_row, cur_col);
                state_n  = POP;
                if (mem_rdata[0] && !mem_rdata[1]) begin
                    mem_wr_en = 1'b1;
                    mem_wdata = {mem_rdata[5:1], 1'b0};
                    if (mem_rdata[5])
                        state_n = DONE;
                    else if (mem_rdata[4:2] == 3'd0)
                        state_n = EXPAND;
                end
            end
            EXPAND: if (k == 3'd7) state_n = POP;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State, FIFO bookkeeping, queued bitmap and sticky result flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            cnt      <= '0;
            queued   <= '0;
            cur_row  <= '0;
            cur_col  <= '0;
            k        <= '0;
            bomb_hit <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                queued             <= '0;
                queued[start_addr] <= 1'b1;
                rd_ptr             <= '0;
                wr_ptr             <= ptr_inc('0);
                cnt                <= CNTW'(1);
                bomb_hit           <= 1'b0;
                overflow           <= 1'b0;
            end
            if (pop_en) begin
                cur_row <= head_row;
                cur_col <= head_col;
                rd_ptr  <= ptr_inc(rd_ptr);
                cnt     <= cnt - CNTW'(1);
            end
            if (state == CHECK)
                k <= '0;
            else if (state == EXPAND)
                k <= k + 3'd1;
            if (mem_wr_en && mem_rdata[5])
                bomb_hit <= 1'b1;
            if (nb_push) begin
                queued[nb_addr] <= 1'b1;
                wr_ptr          <= ptr_inc(wr_ptr);
                cnt             <= cnt + CNTW'(1);
            end
            if (nb_drop)
                overflow <= 1'b1;
        end
    end

    // FIFO storage; contents are only meaningful below cnt, so no reset.
    always_ff @(posedge clk) begin
        if (accept)
            fifo_mem[PW'(0)] <= {start_row, start_col};
        else if (nb_push)
            fifo_mem[wr_ptr] <= {nb_row, nb_col};
    end

`ifdef MS_REVEAL_STATS_EN
    // Number of cells uncovered in the current run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            revealed_count <= '0;
        else if (accept)
            revealed_count <= '0;
        else if (mem_wr_en)
            revealed_count <= revealed_count + (AW+1)'(1);
    end
`endif

endmodule

// File: tb/tb_minesweeper_reveal_engine.sv
// Directed bench for minesweeper_reveal_engine (16x16, plus a QDEPTH=4 instance).
// Board RAM models have 1-cycle read latency.
module tb_minesweeper_reveal_engine;

    localparam int N = 256;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start = 1'b0, start4 = 1'b0;
    logic [3:0] start_row = '0, start_col = '0;
    logic [3:0] start_row4 = '0, start_col4 = '0;
    logic       busy, done, bomb_hit, overflow, mem_rd_en, mem_wr_en;
    logic       busy4, done4, bomb_hit4, overflow4, mem_rd_en4, mem_wr_en4;
    logic [7:0] mem_addr, mem_addr4;
    logic [5:0] mem_rdata = '0, mem_wdata, mem_rdata4 = '0, mem_wdata4;
`ifdef MS_REVEAL_STATS_EN
    logic [8:0] revealed_count, revealed_count4;
`endif

    logic [5:0] ram  [N];
    logic [5:0] ram4 [N];
    int wcnt [N];
    int wr_total, rd_total;
    int checks = 0, errors = 0;
    int cyc, bad;

    minesweeper_reveal_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .start_row(start_row), .start_col(start_col),
        .busy(busy), .done(done), .bomb_hit(bomb_hit), .overflow(overflow),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
        .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata)
`ifdef MS_REVEAL_STATS_EN
        , .revealed_count(revealed_count)
`endif
    );

    minesweeper_reveal_engine #(.QDEPTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4),
        .start_row(start_row4), .start_col(start_col4),
        .busy(busy4), .done(done4), .bomb_hit(bomb_hit4), .overflow(overflow4),
        .mem_addr(mem_addr4), .mem_rd_en(mem_rd_en4), .mem_rdata(mem_rdata4),
        .mem_wr_en(mem_wr_en4), .mem_wdata(mem_wdata4)
`ifdef MS_REVEAL_STATS_EN
        , .revealed_count(revealed_count4)
`endif
    );

    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rdata <= ram[mem_addr];
            rd_total++;
        end
        if (mem_wr_en) begin
            ram[mem_addr] <= mem_wdata;
            wcnt[mem_addr]++;
            wr_total++;
        end
    end

    always @(posedge clk) begin
        if (mem_rd_en4) mem_rdata4 <= ram4[mem_addr4];
        if (mem_wr_en4) ram4[mem_addr4] <= mem_wdata4;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [5:0] v);
        for (int i = 0; i < N; i++) begin
            ram[i]  = v;
            ram4[i] = v;
            wcnt[i] = 0;
        end
        wr_total = 0;
        rd_total = 0;
    endtask

    task automatic go(input bit sel, input logic [3:0] r, input logic [3:0] c,
                      output int n);
        @(negedge clk);
        if (sel) begin
            start4 = 1'b1; start_row4 = r; start_col4 = c;
        end else begin
            start = 1'b1; start_row = r; start_col = c;
        end
        @(negedge clk);
        start  = 1'b0;
        start4 = 1'b0;
        n = 1;
        while (!(sel ? done4 : done) && n < 20000) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        fill(6'h00);
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wr_en", mem_wr_en, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_flags", {bomb_hit, overflow}, 0);
        rst_n = 1'b1;

        // 1: isolated numbered cell
        fill(6'h05);
        ram[17] = 6'h0D;
        go(0, 4'd1, 4'd1, cyc);
        chk("t1_done_cycle", cyc, 4);
        chk("t1_done", done, 1);
        chk("t1_busy_at_done", busy, 1);
        chk("t1_bomb", bomb_hit, 0);
        chk("t1_writes", wr_total, 1);
        chk("t1_wcnt17", wcnt[17], 1);
        chk("t1_wdata", ram[17], 6'h0C);
        @(negedge clk);
        chk("t1_done_pulse", done, 0);
        chk("t1_busy_after", busy, 0);

        // 2: bomb at start
        fill(6'h05);
        ram[0] = 6'h21;
        go(0, 4'd0, 4'd0, cyc);
        chk("t2_done", done, 1);
        chk("t2_bomb", bomb_hit, 1);
        chk("t2_writes", wr_total, 1);
        chk("t2_wdata", ram[0], 6'h20);
        chk("t2_reads", rd_total, 1);

        // 3: whole board zero
        fill(6'h01);
        go(0, 4'd15, 4'd15, cyc);
        chk("t3_done", done, 1);
        chk("t3_writes", wr_total, 256);
        bad = 0;
        for (int i = 0; i < N; i++) if (wcnt[i] != 1) bad++;
        chk("t3_each_once", bad, 0);
        chk("t3_overflow", overflow, 0);
        chk("t3_bomb", bomb_hit, 0);
`ifdef MS_REVEAL_STATS_EN
        chk("t3_revealed", revealed_count, 256);
`endif

        // 4: corner zero block with flagged border cell
        fill(6'h05);
        ram[14] = 6'h01; ram[15] = 6'h01;
        ram[30] = 6'h01; ram[31] = 6'h01;
        ram[47] = 6'h07;
        go(0, 4'd0, 4'd15, cyc);
        chk("t4_done", done, 1);
        chk("t4_writes", wr_total, 8);
        chk("t4_w14", wcnt[14], 1);
        chk("t4_w15", wcnt[15], 1);
        chk("t4_w30", wcnt[30], 1);
        chk("t4_w31", wcnt[31], 1);
        chk("t4_w13", wcnt[13], 1);
        chk("t4_w29", wcnt[29], 1);
        chk("t4_w45", wcnt[45], 1);
        chk("t4_w46", wcnt[46], 1);
        chk("t4_w47", wcnt[47], 0);

        // 5: small FIFO overflows
        fill(6'h01);
        go(1, 4'd8, 4'd8, cyc);
        chk("t5_done", done4, 1);
        chk("t5_overflow", overflow4, 1);
        @(negedge clk);
        chk("t5_busy_drop", busy4, 0);

        // 6: asynchronous reset mid-flood
        fill(6'h01);
        @(negedge clk);
        start = 1'b1; start_row = 4'd5; start_col = 4'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        chk("t6_busy_before", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_wr_en", mem_wr_en, 0);
        @(negedge clk);
        rst_n = 1'b1;
        fill(6'h05);
        ram[17] = 6'h0D;
        go(0, 4'd1, 4'd1, cyc);
        chk("t6_done_cycle", cyc, 4);
        chk("t6_writes", wr_total, 1);
        chk("t6_wcnt17", wcnt[17], 1);
        chk("t6_bomb", bomb_hit, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
